fb_read_arbiter: RTL and testbench
==================================

Name: fb_read_arbiter

Overview:
- Shares the single read port (addrb/doutb) of the camera frame buffer between two requesters.
- Port 0 is the VGA display path; it is latency-critical and has priority.
- Port 1 is the OLED pixel streamer; it is bursty and tolerant of delay.
- Issues one read per cycle, tags each read with its requester, and returns data through per-port registered outputs with a valid strobe.
- A bounded-wait rule keeps port 1 from being starved.

Parameters:
- C_NB_ADDR, 15, frame buffer address width (pixel index).
- C_NB_DATA, 12, pixel word width (4R/4G/4B).
- C_RD_LAT, 1, memory read latency in clk cycles, from mem_addr to mem_dout valid; legal values 1..3.
- C_MAX_WAIT, 4, cycles port 1 may be denied while requesting before it gets forced priority; legal values 1..15.

Ports:
- clk  in  1  system clock (frame buffer read-port clock).
- rst  in  1  asynchronous active-high reset.
- req0  in  1  port 0 read request; held until gnt0.
- addr0  in  C_NB_ADDR  port 0 read address; stable while req0 high.
- gnt0  out  1  port 0 request accepted this cycle.
- rvalid0  out  1  rdata0 updated this cycle (1-cycle pulse).
- rdata0  out  C_NB_DATA  port 0 read data, held between strobes.
- req1, addr1, gnt1, rvalid1, rdata1: same as port 0, for port 1.
- mem_addr  out  C_NB_ADDR  frame buffer read address (to addrb).
- mem_dout  in  C_NB_DATA  frame buffer read data (from doutb).
- wait1  out  4  current port 1 starvation count (debug/LED).

Behaviour:
- One clock, clk. Async reset rst.
- Reset values: gnt0 = gnt1 = 0 (forced low while rst), rvalid0 = rvalid1 = 0, rdata0 = rdata1 = 0, wait1 = 0, tag pipeline cleared, mem_addr = 0.
- Grant is combinational from the current req0/req1 and the registered wait1. At most one grant per cycle; gnt0 and gnt1 are never both high.
  - Neither request: no grant; mem_addr holds its last value.
  - Only reqN: gntN = 1.
  - Both, and wait1 < C_MAX_WAIT: gnt0 = 1.
  - Both, and wait1 == C_MAX_WAIT: gnt1 = 1 (forced). Port 0 waits exactly one cycle.
- mem_addr = addr of the granted port, combinationally, in the grant cycle.
- Handshake: a request is consumed on the cycle gntN = 1. A requester may keep reqN high with a new addrN on the following cycle (back-to-back). Dropping reqN before a grant is legal; the request is abandoned and no data is returned.
- wait1 register:
  - increments (saturating at C_MAX_WAIT) each cycle req1 = 1 and gnt1 = 0;
  - clears to 0 on gnt1 or when req1 = 0.
- Tag pipeline: a C_RD_LAT-deep shift register of {valid, port} entries. The grant cycle pushes {1, N}; a cycle with no grant pushes {0, x}.
- At the pipeline output:
  - if valid and port = N: rdataN <= mem_dout and rvalidN <= 1 on the next edge;
  - otherwise rvalidN <= 0 and rdataN holds.
- Latency from grant edge to rvalid high: C_RD_LAT + 1 cycles. Reads return in grant order, one per cycle maximum across both ports.
- Throughput: 1 read/cycle total. Port 1 is guaranteed at least 1 grant per C_MAX_WAIT + 1 cycles under continuous port 0 load.
- Reset mid-operation: in-flight reads are discarded; no rvalid is emitted for them after rst deasserts.
- Addresses are passed through unchecked. The requesters keep addresses below c_img_pxls.
- Simultaneous events:
  - Forced port 1 grant plus a port 0 request: port 0 is granted the next cycle if it still requests.
  - Port 1 dropping req1 in the cycle wait1 saturates: no grant, wait1 clears.

Test Plan:
- Reset: assert rst with req0 = req1 = 1 -> gnt0 = gnt1 = 0, rvalid0/1 = 0, rdata0/1 = 0, wait1 = 0. Deassert -> gnt0 = 1 in the same cycle.
- Single port 0: req0 with addr0 = 0x0005, memory model returns addr XOR 0xABC after C_RD_LAT = 1 -> gnt0 pulse, rvalid0 two cycles after the grant edge, rdata0 = 0xAB9, rvalid1 never asserts.
- Contention starvation bound: req0 and req1 held high continuously, C_MAX_WAIT = 4 -> grant pattern 0,0,0,0,1 repeating; wait1 sequence 1,2,3,4,0; each return is routed to the correct port.
- Back-to-back: port 1 alone, addr1 = 10, 11, 12 on consecutive cycles -> three consecutive rvalid1 pulses with data for 10, 11, 12 in order. Repeat with C_RD_LAT = 3, same order, latency 4.
- Abandoned request: req1 high for 2 cycles under port 0 load, then dropped -> no gnt1, wait1 returns to 0, no rvalid1.
- Mid-flight reset: grant a port 0 read, assert rst on the next cycle -> no rvalid0 after release, rdata0 = 0.

Source files
------------

// File: rtl/fb_read_arbiter_if.sv
// fb_read_arbiter_if: one requester's read channel into the frame buffer arbiter.
interface fb_read_arbiter_if #(
  parameter int C_NB_ADDR = 15,
  parameter int C_NB_DATA = 12
);
  logic                 req;
  logic [C_NB_ADDR-1:0] addr;
  logic                 gnt;
  logic                 rvalid;
  logic [C_NB_DATA-1:0] rdata;
  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/fb_read_arbiter.sv
// fb_read_arbiter: shares the frame buffer read port between VGA (port 0, priority) and OLED (port 1, bounded wait).
module fb_read_arbiter #(
  parameter int C_NB_ADDR  = 15,
  parameter int C_NB_DATA  = 12,
  parameter int C_RD_LAT   = 1,
  parameter int C_MAX_WAIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  fb_read_arbiter_if.slave     p0,
  fb_read_arbiter_if.slave     p1,
  output logic [C_NB_ADDR-1:0] mem_addr,
  input  logic [C_NB_DATA-1:0] mem_dout,
  output logic [3:0]           wait1
);
  localparam logic [3:0] MAXW = 4'(C_MAX_WAIT);
  logic                 force1, gnt0, gnt1, out_v, out_p;
  logic [C_NB_ADDR-1:0] addr_q;
  logic [C_RD_LAT-1:0]  tag_v, tag_p;
  always_comb begin
    force1   = p1.req && wait1 == MAXW;
    gnt0     = !rst && p0.req && !force1;
    gnt1     = !rst && p1.req && (!p0.req || force1);
    mem_addr = gnt1 ? p1.addr : gnt0 ? p0.addr : addr_q;
    out_v    = tag_v[C_RD_LAT-1];
    out_p    = tag_p[C_RD_LAT-1];
  end
  assign p0.gnt = gnt0;
  assign p1.gnt = gnt1;
  // tag_p marks reads issued for port 1; tag_v marks cycles that issued any read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q    <= '0;
      wait1     <= '0;
      tag_v     <= '0;
      tag_p     <= '0;
      p0.rvalid <= 1'b0;
      p1.rvalid <= 1'b0;
      p0.rdata  <= '0;
      p1.rdata  <= '0;
    end else begin
      addr_q    <= mem_addr;
      wait1     <= (!p1.req || gnt1) ? 4'd0 : (wait1 == MAXW) ? wait1 : wait1 + 4'd1;
      tag_v     <= C_RD_LAT'({tag_v, gnt0 | gnt1});
      tag_p     <= C_RD_LAT'({tag_p, gnt1});
      p0.rvalid <= out_v && !out_p;
      p1.rvalid <= out_v && out_p;
      if (out_v && !out_p) p0.rdata <= mem_dout;
      if (out_v && out_p) p1.rdata <= mem_dout;
    end
  end
endmodule

// File: tb/tb_fb_read_arbiter.sv
// tb_fb_read_arbiter: directed bench for fb_read_arbiter at read latency 1 (dut) and 3 (dut3).
module tb_fb_read_arbiter;
  logic        clk, rst;
  logic [14:0] ma, mb, pa;
  logic [14:0] pb [3];
  logic [11:0] da, db;
  logic [3:0]  wa, wb;
  int checks = 0;
  int errors = 0;

  fb_read_arbiter_if #(.C_NB_ADDR(15), .C_NB_DATA(12)) a0 (), a1 (), b0 (), b1 ();

  fb_read_arbiter #(.C_NB_ADDR(15), .C_NB_DATA(12), .C_RD_LAT(1), .C_MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst), .p0(a0), .p1(a1), .mem_addr(ma), .mem_dout(da), .wait1(wa));
  fb_read_arbiter #(.C_NB_ADDR(15), .C_NB_DATA(12), .C_RD_LAT(3), .C_MAX_WAIT(4)) dut3 (
    .clk(clk), .rst(rst), .p0(b0), .p1(b1), .mem_addr(mb), .mem_dout(db), .wait1(wb));

  always #5 clk = ~clk;

  // memory models: data = addr ^ 0xABC after the configured read latency
  always @(posedge clk) begin
    pa    <= ma;
    pb[0] <= mb;
    pb[1] <= pb[0];
    pb[2] <= pb[1];
  end
  assign da = pa[11:0] ^ 12'hABC;
  assign db = pb[2][11:0] ^ 12'hABC;

  task automatic test_reset;
    rst = 1'b1;
    a0.req = 1'b1; a1.req = 1'b1; a0.addr = 15'h3; a1.addr = 15'h4;
    b0.req = 1'b0; b1.req = 1'b0; b0.addr = '0; b1.addr = '0;
    @(negedge clk); #1;
    checks++; if (a0.gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt0 got=%0h exp=0", a0.gnt); end
    checks++; if (a1.gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt1 got=%0h exp=0", a1.gnt); end
    checks++; if (a0.rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid0 got=%0h exp=0", a0.rvalid); end
    checks++; if (a1.rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid1 got=%0h exp=0", a1.rvalid); end
    checks++; if (a0.rdata !== 12'h0) begin errors++; $display("FAIL reset_rdata0 got=%0h exp=0", a0.rdata); end
    checks++; if (a1.rdata !== 12'h0) begin errors++; $display("FAIL reset_rdata1 got=%0h exp=0", a1.rdata); end
    checks++; if (wa !== 4'h0) begin errors++; $display("FAIL reset_wait1 got=%0h exp=0", wa); end
    checks++; if (ma !== 15'h0) begin errors++; $display("FAIL reset_mem_addr got=%0h exp=0", ma); end
    rst = 1'b0; #1;
    checks++; if (a0.gnt !== 1'b1) begin errors++; $display("FAIL release_gnt0 got=%0h exp=1", a0.gnt); end
    checks++; if (a1.gnt !== 1'b0) begin errors++; $display("FAIL release_gnt1 got=%0h exp=0", a1.gnt); end
    checks++; if (ma !== 15'h3) begin errors++; $display("FAIL release_mem_addr got=%0h exp=3", ma); end
    a0.req = 1'b0; a1.req = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single_port0;
    logic ev;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      a0.req = (k == 0); a0.addr = 15'h5;
      #1;
      ev = (k == 2);
      if (k == 0) begin
        checks++; if (a0.gnt !== 1'b1) begin errors++; $display("FAIL single_gnt0 got=%0h exp=1", a0.gnt); end
        checks++; if (a1.gnt !== 1'b0) begin errors++; $display("FAIL single_gnt1 got=%0h exp=0", a1.gnt); end
      end
      if (k < 2) begin
        checks++; if (ma !== 15'h5) begin errors++; $display("FAIL single_mem_addr k=%0d got=%0h exp=5", k, ma); end
      end
      checks++; if (a0.rvalid !== ev) begin errors++; $display("FAIL single_rvalid0 k=%0d got=%0h exp=%0h", k, a0.rvalid, ev); end
      checks++; if (a1.rvalid !== 1'b0) begin errors++; $display("FAIL single_rvalid1 k=%0d got=%0h exp=0", k, a1.rvalid); end
      if (k >= 2) begin
        checks++; if (a0.rdata !== 12'hAB9) begin errors++; $display("FAIL single_rdata0 k=%0d got=%0h exp=ab9", k, a0.rdata); end
      end
    end
  endtask

  task automatic test_contention;
    logic        g1;
    logic        exp_p [12];
    logic [11:0] exp_d [12];
    logic [14:0] ea;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      a0.req = 1'b1; a1.req = 1'b1;
      a0.addr = 15'(32'h100 + i); a1.addr = 15'(32'h200 + i);
      #1;
      g1 = (i % 5 == 4);
      ea = g1 ? 15'(32'h200 + i) : 15'(32'h100 + i);
      exp_p[i] = g1;
      exp_d[i] = ea[11:0] ^ 12'hABC;
      checks++; if (a1.gnt !== g1) begin errors++; $display("FAIL cont_gnt1 i=%0d got=%0h exp=%0h", i, a1.gnt, g1); end
      checks++; if (a0.gnt !== !g1) begin errors++; $display("FAIL cont_gnt0 i=%0d got=%0h exp=%0h", i, a0.gnt, !g1); end
      checks++; if (ma !== ea) begin errors++; $display("FAIL cont_mem_addr i=%0d got=%0h exp=%0h", i, ma, ea); end
      checks++; if (wa !== 4'(i % 5)) begin errors++; $display("FAIL cont_wait1 i=%0d got=%0h exp=%0h", i, wa, i % 5); end
      if (i >= 2) begin
        checks++; if (a1.rvalid !== exp_p[i-2]) begin errors++; $display("FAIL cont_rvalid1 i=%0d got=%0h exp=%0h", i, a1.rvalid, exp_p[i-2]); end
        checks++; if (a0.rvalid !== !exp_p[i-2]) begin errors++; $display("FAIL cont_rvalid0 i=%0d got=%0h exp=%0h", i, a0.rvalid, !exp_p[i-2]); end
        if (exp_p[i-2]) begin
          checks++; if (a1.rdata !== exp_d[i-2]) begin errors++; $display("FAIL cont_rdata1 i=%0d got=%0h exp=%0h", i, a1.rdata, exp_d[i-2]); end
        end else begin
          checks++; if (a0.rdata !== exp_d[i-2]) begin errors++; $display("FAIL cont_rdata0 i=%0d got=%0h exp=%0h", i, a0.rdata, exp_d[i-2]); end
        end
      end
    end
    @(negedge clk);
    a0.req = 1'b0; a1.req = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [11:0] tbl [3];
    logic        va, vb;
    tbl[0] = 12'hAB6; tbl[1] = 12'hAB7; tbl[2] = 12'hAB0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      a1.req = (k < 3); b1.req = (k < 3);
      a1.addr = 15'(10 + k); b1.addr = 15'(10 + k);
      #1;
      va = (k >= 2 && k <= 4);
      vb = (k >= 4 && k <= 6);
      if (k < 3) begin
        checks++; if (a1.gnt !== 1'b1) begin errors++; $display("FAIL b2b_gnt1 k=%0d got=%0h exp=1", k, a1.gnt); end
        checks++; if (b1.gnt !== 1'b1) begin errors++; $display("FAIL b2b3_gnt1 k=%0d got=%0h exp=1", k, b1.gnt); end
      end
      checks++; if (a1.rvalid !== va) begin errors++; $display("FAIL b2b_rvalid1 k=%0d got=%0h exp=%0h", k, a1.rvalid, va); end
      checks++; if (b1.rvalid !== vb) begin errors++; $display("FAIL b2b3_rvalid1 k=%0d got=%0h exp=%0h", k, b1.rvalid, vb); end
      checks++; if (b0.rvalid !== 1'b0) begin errors++; $display("FAIL b2b3_rvalid0 k=%0d got=%0h exp=0", k, b0.rvalid); end
      if (va) begin
        checks++; if (a1.rdata !== tbl[k-2]) begin errors++; $display("FAIL b2b_rdata1 k=%0d got=%0h exp=%0h", k, a1.rdata, tbl[k-2]); end
      end
      if (vb) begin
        checks++; if (b1.rdata !== tbl[k-4]) begin errors++; $display("FAIL b2b3_rdata1 k=%0d got=%0h exp=%0h", k, b1.rdata, tbl[k-4]); end
      end
    end
  endtask

  task automatic test_abandon;
    logic [3:0] ew;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      a0.req = (k < 5); a0.addr = 15'h20;
      a1.req = (k < 2); a1.addr = 15'h30;
      #1;
      ew = (k == 1) ? 4'd1 : (k == 2) ? 4'd2 : 4'd0;
      checks++; if (a1.gnt !== 1'b0) begin errors++; $display("FAIL abandon_gnt1 k=%0d got=%0h exp=0", k, a1.gnt); end
      checks++; if (wa !== ew) begin errors++; $display("FAIL abandon_wait1 k=%0d got=%0h exp=%0h", k, wa, ew); end
      checks++; if (a1.rvalid !== 1'b0) begin errors++; $display("FAIL abandon_rvalid1 k=%0d got=%0h exp=0", k, a1.rvalid); end
    end
  endtask

  task automatic test_midflight_reset;
    @(negedge clk);
    a0.req = 1'b1; a0.addr = 15'h7;
    #1;
    checks++; if (a0.gnt !== 1'b1) begin errors++; $display("FAIL mid_gnt0 got=%0h exp=1", a0.gnt); end
    @(negedge clk);
    a0.req = 1'b0; rst = 1'b1;
    #1;
    checks++; if (a0.rvalid !== 1'b0) begin errors++; $display("FAIL mid_rst_rvalid0 got=%0h exp=0", a0.rvalid); end
    checks++; if (a0.rdata !== 12'h0) begin errors++; $display("FAIL mid_rst_rdata0 got=%0h exp=0", a0.rdata); end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      checks++; if (a0.rvalid !== 1'b0) begin errors++; $display("FAIL mid_rvalid0 k=%0d got=%0h exp=0", k, a0.rvalid); end
      checks++; if (a0.rdata !== 12'h0) begin errors++; $display("FAIL mid_rdata0 k=%0d got=%0h exp=0", k, a0.rdata); end
    end
  endtask

  initial begin
    clk = 1'b0;
    test_reset;
    test_single_port0;
    test_contention;
    test_back_to_back;
    test_abandon;
    test_midflight_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
